// File: rtl/booth_seq_mult_pkg.sv
//------------------------------------------------------------------------------
// booth_seq_mult_pkg
// Shared definitions for the radix-2 Booth sequential multiplier:
//   - state_t    : 2-bit controller state encoding (S_IDLE/S_ADD/S_SHIFT/S_DONE)
//   - iter_count : number of Booth iterations for a given operand width
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package booth_seq_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // One extra bit of internal width lets unsigned operands be treated as
  // non-negative two's-complement values, so N = WIDTH+1 iterations.
  function automatic int iter_count(input int width);
    return width + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_seq_mult_if.sv
//------------------------------------------------------------------------------
// booth_seq_mult_if
// Operand/result bundle between the operand registers (master) and the
// multiplier (slave).
//   start        master->slave  request, accepted only when idle
//   signed_mode  master->slave  1 = two's-complement operands
//   multiplicand master->slave  operand M (WIDTH bits)
//   multiplier   master->slave  operand Q (WIDTH bits)
//   busy         slave->master  operation in progress
//   done         slave->master  one-cycle pulse, product valid
//   product      slave->master  2*WIDTH-bit result, held until next acceptance
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface booth_seq_mult_if #(
  parameter int WIDTH = 8
);

  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output busy, done, product
  );

endinterface

`default_nettype wire

// File: rtl/booth_addsub.sv
//------------------------------------------------------------------------------
// booth_addsub
// Combinational N-bit adder/subtractor with wraparound.
//   a_i   : N  minuend / augend
//   b_i   : N  subtrahend / addend
//   sub_i : 1  1 = a_i - b_i, 0 = a_i + b_i
//   sum_o : N  result
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module booth_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] sum_o
);

  // Subtraction as a + ~b + 1 so a single adder serves both operations.
  assign sum_o = a_i + (b_i ^ {N{sub_i}}) + {{(N-1){1'b0}}, sub_i};

endmodule

`default_nettype wire

// File: rtl/booth_seq_mult.sv
//------------------------------------------------------------------------------
// booth_seq_mult
// Parametrised radix-2 Booth sequential multiplier (controller + datapath).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : booth_seq_mult_if.slave (start/signed_mode/multiplicand/multiplier
//          in; busy/done/product out)
// Optional build macro:
//   BOOTH_EARLY_TERM_EN - finish as soon as the remaining multiplier bits
//                         would only cause pure shifts (data-dependent latency)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module booth_seq_mult
  import booth_seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  booth_seq_mult_if.slave     bus
);

  localparam int                CNT_W = $clog2(WIDTH + 2);
  localparam int                N     = iter_count(WIDTH);
  localparam int                PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0]  N_CNT = CNT_W'(N);

  state_t             state_q;
  logic [N-1:0]       m_q;
  logic [N-1:0]       a_q;
  logic [N-1:0]       q_q;
  logic               q1_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PW-1:0]      product_q;
  logic               busy_q;
  logic               done_q;

  logic [N-1:0]       m_ext_d;
  logic [N-1:0]       q_ext_d;
  logic [N-1:0]       addsub_d;
  logic [N-1:0]       a_sh_d;
  logic [N-1:0]       q_sh_d;
  logic               q1_sh_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               last_d;
  logic [PW-1:0]      prod_sh_d;

  // Extension into the N-bit internal width.
  assign m_ext_d = {bus.signed_mode & bus.multiplicand[WIDTH-1], bus.multiplicand};
  assign q_ext_d = {bus.signed_mode & bus.multiplier[WIDTH-1],   bus.multiplier};

  // Pair 10 subtracts, pair 01 adds; Q[0] alone selects the operation and
  // the FSM only commits the result when the pair differs.
  booth_addsub #(
    .N (N)
  ) u_addsub (
    .a_i   (a_q),
    .b_i   (m_q),
    .sub_i (q_q[0]),
    .sum_o (addsub_d)
  );

  // Arithmetic right shift of {A, Q, q_1}.
  assign a_sh_d  = {a_q[N-1], a_q[N-1:1]};
  assign q_sh_d  = {a_q[0], q_q[N-1:1]};
  assign q1_sh_d = q_q[0];
  assign cnt_d   = cnt_q + 1'b1;

`ifdef BOOTH_EARLY_TERM_EN
  logic [CNT_W-1:0]   rem_d;
  logic [N-1:0]       rem_mask_d;

  // If every unprocessed Q bit equals the new q_1, all remaining pairs are
  // 00 or 11, so the rest of the work collapses into one arithmetic shift.
  // With nothing remaining the mask is empty and this reduces to cnt+1 == N.
  assign rem_d      = N_CNT - cnt_d;
  assign rem_mask_d = (N'(1) << rem_d) - N'(1);
  assign last_d     = (((q_sh_d ^ {N{q1_sh_d}}) & rem_mask_d) == '0);
  assign prod_sh_d  = PW'($signed({a_sh_d, q_sh_d}) >>> rem_d);
`else
  assign last_d     = (cnt_d == N_CNT);
  assign prod_sh_d  = {a_sh_d[WIDTH-2:0], q_sh_d};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            m_q     <= m_ext_d;
            a_q     <= '0;
            q_q     <= q_ext_d;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          if (q_q[0] ^ q1_q) begin
            a_q <= addsub_d;
          end
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          a_q   <= a_sh_d;
          q_q   <= q_sh_d;
          q1_q  <= q1_sh_d;
          cnt_q <= cnt_d;
          if (last_d) begin
            // Product is captured on S_DONE entry so it is valid with done.
            product_q <= prod_sh_d;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            state_q <= S_ADD;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_mult.sv
//------------------------------------------------------------------------------
// tb_booth_seq_mult
// Self-checking bench for booth_seq_mult: driver issues operations and queues
// the expected product and latency; a monitor checks each done pulse and the
// busy/product behaviour between them.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_booth_seq_mult;

  localparam int W  = 8;
  localparam int N  = W + 1;
  localparam int PW = 2 * W;
`ifdef BOOTH_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [PW-1:0] prod;
    int            lat;
    int            t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [PW-1:0] last_prod = '0;

  booth_seq_mult_if #(.WIDTH(W)) bus ();

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer multiplication of the interpreted operands.
  function automatic logic [PW-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q,
                                          input logic sm);
    longint a;
    longint b;
    a = sm ? longint'($signed(m)) : longint'(m);
    b = sm ? longint'($signed(q)) : longint'(q);
    return PW'(a * b);
  endfunction

  // Smallest k such that the extended multiplier bits k-1..N-1 are uniform:
  // after k iterations nothing but shifts would remain.
  function automatic int k_min(input logic [W-1:0] q, input logic sm);
    logic [N-1:0] qe;
    bit uni;
    qe = {sm & q[W-1], q};
    for (int k = 1; k <= N; k++) begin
      uni = 1'b1;
      for (int i = k - 1; i < N; i++) if (qe[i] != qe[k-1]) uni = 1'b0;
      if (uni) return k;
    end
    return N;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] q, input logic sm);
    int k;
    k = k_min(q, sm);
    return EARLY ? 2 * k : 2 * N;
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.done) begin
        chk("busy_in_done", PW'(bus.busy), '0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done product=%h", bus.product);
        end else begin
          mon_e = exp_q.pop_front();
          chk("product", bus.product, mon_e.prod);
          chk("latency", PW'(cyc - mon_e.t0 - 1), PW'(mon_e.lat));
          last_prod = mon_e.prod;
        end
      end else if (exp_q.size() != 0) begin
        chk("busy_mid_op", PW'(bus.busy), PW'(1));
        chk("product_hold", bus.product, last_prod);
      end else begin
        chk("busy_idle", PW'(bus.busy), '0);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic sm,
                       input bit hold, input logic [PW-1:0] want);
    int  t0;
    int  n;
    bit  seen;
    exp_t e;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.signed_mode  = sm;
    bus.multiplicand = m;
    bus.multiplier   = q;
    t0 = cyc;
    @(posedge clk);
    e.prod = want;
    e.lat  = exp_lat(q, sm);
    e.t0   = t0;
    exp_q.push_back(e);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (hold) begin
        bus.start        = 1'b1;
        bus.signed_mode  = 1'($urandom);
        bus.multiplicand = W'($urandom);
        bus.multiplier   = W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL op_timeout got=no_done want=done m=%h q=%h", m, q);
      exp_q.delete();
    end
    if (hold) begin
      // start stays high through the S_DONE edge and must not be accepted there.
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] m;
    logic [W-1:0] q;
    logic         sm;
    bit           hold;

    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", PW'(bus.busy), '0);
    chk("rst_done", PW'(bus.done), '0);
    chk("rst_product", bus.product, '0);
    rst = 1'b1;

    do_op(8'd7,   8'hFD, 1'b1, 1'b0, 16'hFFEB);
    do_op(8'hFF,  8'hFF, 1'b0, 1'b0, 16'hFE01);
    do_op(8'h80,  8'h80, 1'b1, 1'b0, 16'h4000);
    do_op(8'h12,  8'h34, 1'b0, 1'b1, 16'h03A8);

    // Reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.signed_mode = 1'b0;
    bus.multiplicand = 8'h21;
    bus.multiplier = 8'h5A;
    @(posedge clk);
    mon_e.prod = 16'h0B9A;
    mon_e.lat = 0;
    mon_e.t0 = 0;
    exp_q.push_back(mon_e);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy", PW'(bus.busy), '0);
    chk("arst_done", PW'(bus.done), '0);
    chk("arst_product", bus.product, '0);
    exp_q.delete();
    last_prod = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    do_op(8'h21, 8'h5A, 1'b0, 1'b0, 16'h0B9A);
    do_op(8'd3,  8'd5,  1'b0, 1'b0, 16'h000F);
    do_op(8'd9,  8'h00, 1'b1, 1'b0, 16'h0000);
    do_op(8'd9,  8'hFF, 1'b1, 1'b0, 16'hFFF7);

    for (int i = 0; i < 1000; i++) begin
      m    = W'($urandom);
      q    = W'($urandom);
      sm   = 1'($urandom);
      hold = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 7))
        0: q = 8'h00;
        1: q = 8'hFF;
        2: q = 8'h80;
        3: m = 8'h80;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      do_op(m, q, sm, hold, model(m, q, sm));
    end

    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
